gate_exhaustive_checker: RTL and testbench

Self-checking stimulus and response stage for 2-input gate modules such as the mux-built AND gate. Upstream, it drives all four `{a,b}` input vectors into the gate under test. Downstream, it samples the gate output `y` after a programmable settle time and compares it against a parameterised truth table. It reports a per-vector fail mask, an error count and a one-cycle `done` pulse, so gate cells can be checked in hardware or in a bench without a `$monitor` printout.

---
 rtl/gate_exhaustive_checker_if.sv | 24 ++
 rtl/gate_exhaustive_checker.sv | 143 ++++++++++++++
 tb/tb_gate_exhaustive_checker.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gate_exhaustive_checker_if.sv
// Groups the stimulus, response and result signals of the gate checker.
// The master modport is the checker side; the slave modport is the gate/bench side.
// Signal names match the checker's port list one-to-one.
interface gate_exhaustive_checker_if;
  logic       start;
  logic       a;
  logic       b;
  logic       y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;

  modport master (
    input  start, y,
    output a, b, busy, done, pass, err_count, fail_mask
  );

  modport slave (
    output start, y,
    input  a, b, busy, done, pass, err_count, fail_mask
  );
endinterface

// File: rtl/gate_exhaustive_checker.sv
// Drives all four {a,b} vectors into a 2-input gate and checks y against TRUTH_TABLE.
// Latency: done pulses 4*(SETTLE_CYCLES+1) cycles after start is accepted.
// Backpressure: none; start is only sampled in IDLE, results held until the next start.
module gate_exhaustive_checker #(
  parameter logic [3:0]  TRUTH_TABLE   = 4'b1000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  gate_exhaustive_checker_if.master gif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Settle counter counts down to zero, so S cycles of SETTLE need a reload of S-1.
  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;
  logic       mismatch;

  assign mismatch = (gif.y != TRUTH_TABLE[idx_q]);

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    mask_d  = mask_q;

    case (state_q)
      ST_IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (gif.start) begin
          err_d   = 3'd0;
          mask_d  = 4'd0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = CNT_RELOAD;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          err_d         = err_q + 3'd1;
          mask_d[idx_q] = 1'b1;
        end
        if (idx_q == 2'd3) begin
          // Final verdict uses the count including this last sample.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (err_d == 3'd0);
          state_d = ST_DONE;
        end else begin
          idx_d      = idx_q + 2'd1;
          {a_d, b_d} = idx_q + 2'd1;
          cnt_d      = CNT_RELOAD;
          state_d    = ST_SETTLE;
        end
      end

      ST_DONE: begin
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      mask_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign gif.a         = a_q;
  assign gif.b         = b_q;
  assign gif.busy      = busy_q;
  assign gif.done      = done_q;
  assign gif.pass      = pass_q;
  assign gif.err_count = err_q;
  assign gif.fail_mask = mask_q;

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Bench for gate_exhaustive_checker: directed runs against AND/zero/OR/NAND gate models.
// Expected run results are queued at start acceptance and checked by monitors on done.
// Two instances cover the default and the NAND/SETTLE_CYCLES=1 configurations.
module tb_gate_exhaustive_checker;
  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_exhaustive_checker_if gif ();
  gate_exhaustive_checker_if gif2 ();

  // Gate models: 0 = AND, 1 = stuck at 0, 2 = OR. dut2 always sees a NAND.
  assign gif.y  = (mode == 0) ? (gif.a & gif.b) : (mode == 1) ? 1'b0 : (gif.a | gif.b);
  assign gif2.y = ~(gif2.a & gif2.b);

  gate_exhaustive_checker dut (
    .clk  (clk),
    .rst_n(rst_n),
    .gif  (gif.master)
  );

  gate_exhaustive_checker #(
    .TRUTH_TABLE  (4'b0111),
    .SETTLE_CYCLES(1)
  ) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .gif  (gif2.master)
  );

  typedef struct {
    logic [2:0] err;
    logic [3:0] mask;
    logic       pass;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  logic prev_done1 = 1'b0;
  logic prev_done2 = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the default instance.
  always @(negedge clk) begin
    exp_t e;
    if (gif.done) begin
      check("done1_pulse_width", prev_done1, 0);
      check("done1_expected", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("done1_err_count", gif.err_count, e.err);
        check("done1_fail_mask", gif.fail_mask, e.mask);
        check("done1_pass", gif.pass, e.pass);
        check("done1_latency", cyc - e.acc, e.lat);
        check("done1_busy", gif.busy, 0);
      end
    end
    prev_done1 <= gif.done;
  end

  // Scoreboard monitor for the NAND instance.
  always @(negedge clk) begin
    exp_t e;
    if (gif2.done) begin
      check("done2_pulse_width", prev_done2, 0);
      check("done2_expected", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("done2_err_count", gif2.err_count, e.err);
        check("done2_fail_mask", gif2.fail_mask, e.mask);
        check("done2_pass", gif2.pass, e.pass);
        check("done2_latency", cyc - e.acc, e.lat);
      end
    end
    prev_done2 <= gif2.done;
  end

  // One run on the default instance with a given gate model and expected result.
  task automatic run1(input int md, input logic [2:0] xerr, input logic [3:0] xmask,
                      input logic xpass, input bit vec, input bit restart);
    exp_t e;
    bit   got;
    mode = md;
    @(negedge clk);
    gif.start = 1'b1;
    @(posedge clk);
    #1;
    gif.start = 1'b0;
    e.err  = xerr;
    e.mask = xmask;
    e.pass = xpass;
    e.lat  = 12;
    e.acc  = cyc;
    q1.push_back(e);
    check("accept_busy", gif.busy, 1);
    check("accept_clr_err", gif.err_count, 0);
    check("accept_clr_mask", gif.fail_mask, 0);
    check("accept_clr_pass", gif.pass, 0);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gif.done) begin
        got = 1'b1;
        break;
      end
      if (restart && k == 4) gif.start = 1'b1;
      if (restart && k == 6) gif.start = 1'b0;
      if (vec && k < 12) begin
        check("vec_ab", {gif.a, gif.b}, k / 3);
        check("vec_busy", gif.busy, 1);
      end
    end
    gif.start = 1'b0;
    check("run1_done_seen", got, 1);
    repeat (2) @(negedge clk);
    check("hold_err_count", gif.err_count, xerr);
    check("hold_fail_mask", gif.fail_mask, xmask);
    check("hold_pass", gif.pass, xpass);
    check("idle_ab", {gif.a, gif.b}, 0);
  endtask

  initial begin
    exp_t e;
    bit   got;
    mode       = 0;
    gif.start  = 1'b0;
    gif2.start = 1'b0;
    rst_n      = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_a", gif.a, 0);
    check("rst_b", gif.b, 0);
    check("rst_busy", gif.busy, 0);
    check("rst_done", gif.done, 0);
    check("rst_pass", gif.pass, 0);
    check("rst_err_count", gif.err_count, 0);
    check("rst_fail_mask", gif.fail_mask, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ideal AND with vector stepping checked cycle by cycle.
    run1(0, 3'd0, 4'b0000, 1'b1, 1'b1, 1'b0);
    // y stuck at 0: only vector 3 mismatches.
    run1(1, 3'd1, 4'b1000, 1'b0, 1'b0, 1'b0);
    // OR against AND table with a stray start mid-run.
    run1(2, 3'd2, 4'b0110, 1'b0, 1'b1, 1'b1);
    // Fresh start after a failing run clears results and passes.
    run1(0, 3'd0, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Reset during vector 2 aborts the run with no done.
    @(negedge clk);
    gif.start = 1'b1;
    @(posedge clk);
    #1;
    gif.start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_vec2", {gif.a, gif.b}, 2);
    check("pre_reset_busy", gif.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_a", gif.a, 0);
    check("midrst_b", gif.b, 0);
    check("midrst_busy", gif.busy, 0);
    check("midrst_done", gif.done, 0);
    check("midrst_pass", gif.pass, 0);
    check("midrst_err_count", gif.err_count, 0);
    check("midrst_fail_mask", gif.fail_mask, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run1(0, 3'd0, 4'b0000, 1'b1, 1'b0, 1'b0);

    // NAND table with one settle cycle on the second instance.
    @(negedge clk);
    gif2.start = 1'b1;
    @(posedge clk);
    #1;
    gif2.start = 1'b0;
    e.err  = 3'd0;
    e.mask = 4'b0000;
    e.pass = 1'b1;
    e.lat  = 8;
    e.acc  = cyc;
    q2.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gif2.done) begin
        got = 1'b1;
        break;
      end
      if (k < 8) check("vec2_ab", {gif2.a, gif2.b}, k / 2);
    end
    check("run2_done_seen", got, 1);

    repeat (4) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
